panda_fetch_ctrl: RTL and testbench
===================================

PANDA_FETCH_CTRL -- requirements
Module: panda_fetch_ctrl

Interface
REQ-001 The block SHALL provide parameters: Width, default 32, address/data width; ResetPc, default 32'h0000_0000, first fetch address.
REQ-002 The block SHALL provide these ports:
  clk_i  in  1  clock
  rst_ni  in  1  reset, asynchronous, active-low
  instr_req_o  out  1  memory request valid
  instr_gnt_i  in  1  memory accepts request
  instr_addr_o  out  Width  request address
  instr_rvalid_i  in  1  response data valid
  instr_rdata_i  in  Width  response data
  redirect_i  in  1  branch/jump taken
  redirect_target_i  in  Width  new PC
  stall_i  in  1  decode cannot accept
  fetch_valid_o  out  1  instruction presented
  fetch_instr_o  out  Width  instruction word
  fetch_pc_o  out  Width  PC of presented instruction
  fetch_pc_inc_o  out  Width  fetch_pc_o + 4

Function
REQ-003 The block SHALL implement FSM states IDLE, REQ, WAIT, HOLD with at most one outstanding memory transaction.
REQ-004 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-005 In REQ: instr_req_o=1, instr_addr_o=pc_q; instr_addr_o SHALL stay stable until instr_gnt_i; on grant, go to WAIT.
REQ-006 In WAIT: on instr_rvalid_i with discard_q=0, capture instr_rdata_i and go to HOLD; on instr_rvalid_i with discard_q=1, drop data, clear discard_q, load pc_q from the latched target and go to REQ.
REQ-007 In HOLD: fetch_valid_o=1; when stall_i=0 the instruction is consumed, pc_q becomes pc_q+4, and the state goes to REQ.
REQ-008 A redirect in REQ (before or with grant) or in WAIT SHALL set discard_q and latch the target; a later redirect before the response SHALL overwrite the latched target.
REQ-009 A redirect in REQ without grant SHALL NOT change instr_addr_o; the granted request completes and its response is discarded.
REQ-010 A redirect in WAIT coinciding with instr_rvalid_i SHALL discard that response and go to REQ at the target next cycle.
REQ-011 A redirect in HOLD SHALL take priority over consumption: drop the held instruction, set pc_q to the target, go to REQ, and deassert fetch_valid_o next cycle.
REQ-012 redirect_target_i[1:0] SHALL be treated as 2'b00.
REQ-013 pc_q+4 SHALL wrap modulo 2^Width with no overflow flag.
REQ-014 fetch_pc_o and fetch_pc_inc_o SHALL be registered with the captured instruction; fetch_valid_o SHALL be 0 outside HOLD.
REQ-015 Minimum latency with same-cycle grant and next-cycle rvalid: fetch_valid_o rises 2 cycles after instr_req_o rises.
REQ-016 instr_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-017 On rst_ni=0: state=IDLE, pc_q=ResetPc, discard_q=0, instr_req_o=0, instr_addr_o=ResetPc, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=ResetPc, fetch_pc_inc_o=ResetPc+4.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction; a response arriving after reset release, before the first request, SHALL be ignored.

Structure
REQ-019 The FSM enum fetch_state_e (IDLE, REQ, WAIT, HOLD) SHALL live in panda_pkg.
REQ-020 The pc_q+4 increment SHALL use one panda_adder instance (subtract_i=0, operand_b=4); all other logic SHALL be local.

Verification
REQ-021 Reset, then gnt same cycle and rvalid next cycle, stall_i=0 -> addresses 0x0, 0x4, 0x8 issued; fetch_valid_o first rises at cycle 3 after reset release.
REQ-022 Hold gnt low for 3 cycles with redirect to 0x100 in the 2nd cycle -> instr_addr_o stays 0x0 until grant; response dropped; next request is 0x100.
REQ-023 In HOLD at PC 0x20, stall_i=1 for 4 cycles -> fetch_instr_o and fetch_pc_o=0x20 stable, no new request; stall_i=0 -> next request 0x24.
REQ-024 In HOLD, redirect to 0x203 with stall_i=0 -> held instruction dropped; next request 0x200; fetch_pc_o=0x200 on delivery.
REQ-025 With pc_q=0xFFFF_FFFC, consume -> next request address 0x0000_0000.
REQ-026 Assert rst_ni=0 during WAIT, release, then inject rvalid -> response ignored; first request at ResetPc.

Source files
------------

// File: rtl/panda_pkg.sv
// panda_pkg: shared types for the panda fetch front end.
// Holds the fetch FSM state encoding and word-size constants.
package panda_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam int unsigned InstrBytes = 4;

endpackage

// File: rtl/panda_adder.sv
// panda_adder: plain Width-bit add/subtract, result wraps, no carry out.
// Ports: operand_a_i, operand_b_i, subtract_i -> result_o.
module panda_adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] result_o
);

  assign result_o = subtract_i ? (operand_a_i - operand_b_i)
                               : (operand_a_i + operand_b_i);

endmodule

// File: rtl/panda_fetch_ctrl.sv
// panda_fetch_ctrl: single-outstanding instruction fetch FSM.
// Ports: instr_* memory req/gnt/rvalid, redirect_*, stall_i, fetch_* to decode.
module panda_fetch_ctrl
  import panda_pkg::*;
#(
  parameter int unsigned      Width   = 32,
  parameter logic [Width-1:0] ResetPc = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             instr_req_o,
  input  logic             instr_gnt_i,
  output logic [Width-1:0] instr_addr_o,
  input  logic             instr_rvalid_i,
  input  logic [Width-1:0] instr_rdata_i,
  input  logic             redirect_i,
  input  logic [Width-1:0] redirect_target_i,
  input  logic             stall_i,
  output logic             fetch_valid_o,
  output logic [Width-1:0] fetch_instr_o,
  output logic [Width-1:0] fetch_pc_o,
  output logic [Width-1:0] fetch_pc_inc_o
);

  localparam logic [Width-1:0] Four      = Width'(InstrBytes);
  localparam logic [Width-1:0] AlignMask = ~Width'(3);

  fetch_state_e     state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] tgt_q, tgt_d;
  logic             discard_q, discard_d;
  logic [Width-1:0] instr_q;
  logic [Width-1:0] fpc_q;
  logic [Width-1:0] fpc_inc_q;

  logic [Width-1:0] pc_inc;
  logic [Width-1:0] redir_pc;
  logic             capture;
  logic             req;
  logic             valid;

  assign redir_pc = redirect_target_i & AlignMask;

  panda_adder #(
    .Width(Width)
  ) u_pc_inc (
    .operand_a_i(pc_q),
    .operand_b_i(Four),
    .subtract_i (1'b0),
    .result_o   (pc_inc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    discard_d = discard_q;
    capture   = 1'b0;
    req       = 1'b0;
    valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_i) pc_d = redir_pc;
      end
      REQ: begin
        req = 1'b1;
        // Address stays on pc_q; the redirect is applied
        // once the in-flight response has been dropped.
        if (redirect_i) begin
          discard_d = 1'b1;
          tgt_d     = redir_pc;
        end
        if (instr_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_i) begin
          discard_d = 1'b1;
          tgt_d     = redir_pc;
        end
        if (instr_rvalid_i) begin
          if (discard_q || redirect_i) begin
            discard_d = 1'b0;
            pc_d      = redirect_i ? redir_pc : tgt_q;
            state_d   = REQ;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        valid = 1'b1;
        // Redirect wins over consumption.
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (!stall_i) begin
          pc_d    = pc_inc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= ResetPc;
      tgt_q     <= ResetPc;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q   <= '0;
      fpc_q     <= ResetPc;
      fpc_inc_q <= ResetPc + Four;
    end else if (capture) begin
      instr_q   <= instr_rdata_i;
      fpc_q     <= pc_q;
      fpc_inc_q <= pc_inc;
    end
  end

  assign instr_req_o    = req;
  assign instr_addr_o   = pc_q;
  assign fetch_valid_o  = valid;
  assign fetch_instr_o  = instr_q;
  assign fetch_pc_o     = fpc_q;
  assign fetch_pc_inc_o = fpc_inc_q;

endmodule

// File: tb/tb_panda_fetch_ctrl.sv
// tb_panda_fetch_ctrl: directed + random bench for panda_fetch_ctrl.
// Memory and expected-PC stream are modelled at transaction level.
module tb_panda_fetch_ctrl;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         instr_req_o;
  logic         instr_gnt_i;
  logic [W-1:0] instr_addr_o;
  logic         instr_rvalid_i;
  logic [W-1:0] instr_rdata_i;
  logic         redirect_i;
  logic [W-1:0] redirect_target_i;
  logic         stall_i;
  logic         fetch_valid_o;
  logic [W-1:0] fetch_instr_o;
  logic [W-1:0] fetch_pc_o;
  logic [W-1:0] fetch_pc_inc_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  panda_fetch_ctrl #(
    .Width  (W),
    .ResetPc(32'h0000_0000)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .instr_req_o      (instr_req_o),
    .instr_gnt_i      (instr_gnt_i),
    .instr_addr_o     (instr_addr_o),
    .instr_rvalid_i   (instr_rvalid_i),
    .instr_rdata_i    (instr_rdata_i),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .stall_i          (stall_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_instr_o    (fetch_instr_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_pc_inc_o   (fetch_pc_inc_o)
  );

  // model state
  logic [W-1:0] exp_pc;
  bit           fresh;
  bit           drop_next;
  bit           pending;
  int           lat_cnt;
  logic [W-1:0] pend_addr;
  bit           held_req;
  logic [W-1:0] held_addr;
  int           cyc;
  int           first_valid;
  logic [W-1:0] gnt_q[$];

  // per-cycle stimulus knobs
  bit           k_gnt, k_stall, k_redir, k_spur;
  logic [W-1:0] k_tgt;
  int           k_lat;

  function automatic logic [W-1:0] mem(input logic [W-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [W-1:0] gq(input int i);
    if (i < gnt_q.size()) return gnt_q[i];
    return 'x;
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_pc      = '0;
    fresh       = 1'b1;
    drop_next   = 1'b0;
    pending     = 1'b0;
    lat_cnt     = 0;
    held_req    = 1'b0;
    cyc         = 0;
    first_valid = -1;
    gnt_q.delete();
  endtask

  task automatic do_reset();
    rst_ni            = 1'b0;
    instr_gnt_i       = 1'b0;
    instr_rvalid_i    = 1'b0;
    instr_rdata_i     = '0;
    redirect_i        = 1'b0;
    redirect_target_i = '0;
    stall_i           = 1'b0;
    #1;
    chk("rst_req", W'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_valid", W'(fetch_valid_o), 32'd0);
    chk("rst_instr", fetch_instr_o, 32'h0);
    chk("rst_pc", fetch_pc_o, 32'h0);
    chk("rst_pc_inc", fetch_pc_inc_o, 32'h4);
    @(negedge clk_i);
    @(negedge clk_i);
    model_clear();
    rst_ni = 1'b1;
  endtask

  // Observe at negedge, drive the next edge, advance the model.
  task automatic cycle();
    bit rv;
    if (fetch_valid_o && first_valid < 0) first_valid = cyc;
    if (drop_next) chk("valid_drop", W'(fetch_valid_o), 32'd0);
    if (fetch_valid_o && fresh) begin
      chk("deliv_pc", fetch_pc_o, exp_pc);
      chk("deliv_instr", fetch_instr_o, mem(exp_pc));
      chk("deliv_inc", fetch_pc_inc_o, exp_pc + 32'd4);
    end
    if (held_req) begin
      chk("req_held", W'(instr_req_o), 32'd1);
      chk("addr_stable", instr_addr_o, held_addr);
    end
    if (instr_req_o) chk("one_outstanding", W'(pending), 32'd0);

    rv                = pending && lat_cnt == 0;
    instr_rvalid_i    = rv || (!pending && k_spur);
    instr_rdata_i     = rv ? mem(pend_addr) : W'($urandom);
    instr_gnt_i       = k_gnt;
    stall_i           = k_stall;
    redirect_i        = k_redir;
    redirect_target_i = k_tgt;

    if (rv) pending = 1'b0;
    else if (pending) lat_cnt--;
    if (instr_req_o && k_gnt) begin
      pending   = 1'b1;
      pend_addr = instr_addr_o;
      lat_cnt   = k_lat;
      gnt_q.push_back(instr_addr_o);
    end
    held_req  = instr_req_o && !k_gnt;
    held_addr = instr_addr_o;
    fresh     = !(fetch_valid_o && k_stall && !k_redir);
    drop_next = fetch_valid_o && (k_redir || !k_stall);
    if (k_redir) exp_pc = k_tgt & ~32'd3;
    else if (fetch_valid_o && !k_stall) exp_pc = exp_pc + 32'd4;
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!fetch_valid_o && n < lim) begin
      cycle();
      n++;
    end
    chk("wait_valid", W'(fetch_valid_o), 32'd1);
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    k_gnt   = 1'b0;
    k_stall = 1'b0;
    k_redir = 1'b0;
    k_spur  = 1'b0;
    k_tgt   = '0;
    k_lat   = 0;
    model_clear();
    @(negedge clk_i);
    do_reset();

    // minimum latency, sequential stream
    k_gnt = 1'b1;
    repeat (12) cycle();
    chk("first_valid_cyc", W'(first_valid), 32'd3);
    chk("seq_addr0", gq(0), 32'h0);
    chk("seq_addr1", gq(1), 32'h4);
    chk("seq_addr2", gq(2), 32'h8);

    // redirect while request waits for grant
    do_reset();
    k_gnt = 1'b0;
    cycle();
    cycle();
    k_redir = 1'b1;
    k_tgt   = 32'h100;
    cycle();
    k_redir = 1'b0;
    cycle();
    k_gnt = 1'b1;
    k_lat = 1;
    cycle();
    wait_valid(20);
    chk("nogrant_redir_pc", fetch_pc_o, 32'h100);
    chk("nogrant_addr0", gq(0), 32'h0);
    chk("nogrant_addr1", gq(1), 32'h100);

    // stall in HOLD after a HOLD redirect to 0x20
    do_reset();
    k_gnt   = 1'b1;
    k_lat   = 0;
    k_stall = 1'b1;
    wait_valid(10);
    k_redir = 1'b1;
    k_tgt   = 32'h20;
    cycle();
    k_redir = 1'b0;
    wait_valid(10);
    chk("stall_pc", fetch_pc_o, 32'h20);
    held = fetch_instr_o;
    for (int i = 0; i < 4; i++) begin
      chk("stall_instr", fetch_instr_o, held);
      chk("stall_pc_hold", fetch_pc_o, 32'h20);
      chk("stall_no_req", W'(instr_req_o), 32'd0);
      cycle();
    end
    k_stall = 1'b0;
    n = gnt_q.size();
    repeat (3) cycle();
    chk("stall_next_addr", gq(n), 32'h24);

    // HOLD redirect with misaligned target
    k_stall = 1'b1;
    wait_valid(10);
    k_redir = 1'b1;
    k_tgt   = 32'h203;
    k_stall = 1'b0;
    n = gnt_q.size();
    cycle();
    k_redir = 1'b0;
    k_stall = 1'b1;
    chk("hold_redir_valid", W'(fetch_valid_o), 32'd0);
    wait_valid(10);
    chk("hold_redir_addr", gq(n), 32'h200);
    chk("hold_redir_pc", fetch_pc_o, 32'h200);

    // PC wrap
    k_redir = 1'b1;
    k_tgt   = 32'hFFFF_FFFC;
    cycle();
    k_redir = 1'b0;
    wait_valid(10);
    chk("wrap_pc", fetch_pc_o, 32'hFFFF_FFFC);
    chk("wrap_inc", fetch_pc_inc_o, 32'h0);
    n = gnt_q.size();
    k_stall = 1'b0;
    repeat (2) cycle();
    chk("wrap_addr", gq(n), 32'h0);

    // reset during WAIT, stray response afterwards
    k_lat = 6;
    n = 0;
    while (!pending && n < 10) begin
      cycle();
      n++;
    end
    chk("reach_wait", W'(pending), 32'd1);
    cycle();
    do_reset();
    k_lat  = 0;
    k_spur = 1'b1;
    cycle();
    cycle();
    k_spur = 1'b0;
    wait_valid(10);
    chk("post_rst_addr", gq(0), 32'h0);
    chk("post_rst_pc", fetch_pc_o, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      k_gnt   = $urandom_range(0, 3) != 0;
      k_lat   = $urandom_range(0, 3);
      k_stall = $urandom_range(0, 2) == 0;
      k_redir = $urandom_range(0, 15) == 0;
      k_tgt   = W'($urandom);
      k_spur  = $urandom_range(0, 7) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
